cache_done_seq: RTL and testbench



---
 rtl/cache_done_seq_pkg.sv | 28 ++
 rtl/cache_done_seq_lat_counter.sv | 26 ++
 rtl/cache_done_seq.sv | 121 ++++++++++++
 tb/tb_cache_done_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cache_done_seq_pkg.sv
// Shared types and default latencies for the cache completion sequencer.
package cache_pkg;

  typedef enum logic [1:0] {
    RD_HIT  = 2'd0,
    RD_MISS = 2'd1,
    WR_HIT  = 2'd2,
    WR_MISS = 2'd3
  } cache_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } seq_state_e;

  localparam int DEF_LAT_W    = 4;
  localparam int DEF_HIT_LAT  = 2;
  localparam int DEF_MISS_LAT = 3;
  localparam int DEF_WB_LAT   = 2;
  localparam int DEF_CNT_W    = 16;

  // Read wins when both strobes are high, so the class keys off is_wr = ~re.
  function automatic cache_op_e op_class(input logic is_wr, input logic is_hit);
    if (is_wr) return is_hit ? WR_HIT : WR_MISS;
    else       return is_hit ? RD_HIT : RD_MISS;
  endfunction

endpackage

// File: rtl/cache_done_seq_lat_counter.sv
// Loadable down-counter that stops at zero; zero flags the terminal count.
module lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cache_done_seq.sv
// Cache completion sequencer: one op in flight, per-class latency, tagged done pulse.
// Statistics counters are built only when CACHE_DONE_STATS_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting; a re/we edge is accepted and the latency loaded
// ST_BUSY | op in flight; counter running, new requests dropped
module cache_done_seq
  import cache_pkg::*;
#(
  parameter int LAT_W    = DEF_LAT_W,
  parameter int HIT_LAT  = DEF_HIT_LAT,
  parameter int MISS_LAT = DEF_MISS_LAT,
  parameter int WB_LAT   = DEF_WB_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re,
  input  logic             we,
  input  logic             hit,
  input  logic             dirty,
  output logic             busy,
  output logic             done,
  output logic [1:0]       done_op,
  output logic             done_wb,
  output logic             err,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int MAX_LAT = (1 << LAT_W) - 1;
  localparam logic [LAT_W-1:0] HIT_LD  = LAT_W'(HIT_LAT - 1);
  localparam logic [LAT_W-1:0] MISS_LD = LAT_W'(MISS_LAT - 1);
  localparam logic [LAT_W-1:0] WB_LD   = LAT_W'(MISS_LAT + WB_LAT - 1);

  initial begin
    if (HIT_LAT < 1 || MISS_LAT < 1 || WB_LAT < 0 ||
        HIT_LAT > MAX_LAT || MISS_LAT + WB_LAT > MAX_LAT)
      $fatal(1, "cache_done_seq: illegal latency parameters");
  end

  seq_state_e       state;
  cache_op_e        op_q;
  logic             wb_q;
  logic             req;
  logic             load;
  logic [LAT_W-1:0] load_val;
  logic             cnt_zero;

  assign req  = re | we;
  assign load = (state == ST_IDLE) && req;

  always_comb begin
    load_val = MISS_LD;
    if (hit)        load_val = HIT_LD;
    else if (dirty) load_val = WB_LD;
  end

  lat_counter #(.W(LAT_W)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_op <= 2'd0;
      done_wb <= 1'b0;
      err     <= 1'b0;
      op_q    <= RD_HIT;
      wb_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: if (req) begin
          op_q  <= op_class(~re, hit);
          wb_q  <= ~hit & dirty;
          err   <= re & we;
          state <= ST_BUSY;
          busy  <= 1'b1;
        end
        ST_BUSY: if (cnt_zero) begin
          done    <= 1'b1;
          done_op <= op_q;
          done_wb <= wb_q;
          state   <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CACHE_DONE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (load && hit && hit_cnt != '1)   hit_cnt  <= hit_cnt + CNT_W'(1);
      if (load && !hit && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
      if ((state == ST_BUSY) && req && drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_done_seq.sv
// Bench for cache_done_seq: directed vector table, random run against an
// edge-counting transaction model, and a HIT_LAT=1 / CNT_W=2 saturation run.
module tb_cache_done_seq;
  import cache_pkg::*;

`ifdef CACHE_DONE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, re = 1'b0, we = 1'b0, hit = 1'b0, dirty = 1'b0;
  logic        busy, done, done_wb, err;
  logic [1:0]  done_op;
  logic [15:0] hit_cnt, miss_cnt, drop_cnt;

  logic        f_rst = 1'b1, f_re = 1'b0, f_we = 1'b0, f_hit = 1'b0, f_dirty = 1'b0;
  logic        f_busy, f_done, f_done_wb, f_err;
  logic [1:0]  f_done_op;
  logic [1:0]  f_hit_cnt, f_miss_cnt, f_drop_cnt;

  cache_done_seq u_dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .hit(hit), .dirty(dirty),
    .busy(busy), .done(done), .done_op(done_op), .done_wb(done_wb), .err(err),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .drop_cnt(drop_cnt)
  );

  cache_done_seq #(.HIT_LAT(1), .CNT_W(2)) u_fast (
    .clk(clk), .rst(f_rst), .re(f_re), .we(f_we), .hit(f_hit), .dirty(f_dirty),
    .busy(f_busy), .done(f_done), .done_op(f_done_op), .done_wb(f_done_wb), .err(f_err),
    .hit_cnt(f_hit_cnt), .miss_cnt(f_miss_cnt), .drop_cnt(f_drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       re, we, hit, dirty, rst;
    logic       busy, done;
    logic [1:0] op;
    logic       wb, err;
    int         hc, mc, dc;
  } vec_t;

  function automatic vec_t mk(input logic r, w, h, d, rs, b, dn, input logic [1:0] o,
                              input logic wbf, e, input int hc, mc, dc);
    vec_t v;
    v.re = r; v.we = w; v.hit = h; v.dirty = d; v.rst = rs;
    v.busy = b; v.done = dn; v.op = o; v.wb = wbf; v.err = e;
    v.hc = hc; v.mc = mc; v.dc = dc;
    return v;
  endfunction

  // Transaction-level model: completion edge = acceptance edge + class latency.
  int        m_edge, m_done_edge, m_hit, m_miss, m_drop;
  bit        m_pend, e_busy, e_done, e_err, e_wb, m_wb;
  cache_op_e m_op, e_op;
  localparam int SAT16 = 65535;

  function automatic int lat_of(input bit h, input bit d);
    if (h) return DEF_HIT_LAT;
    return d ? DEF_MISS_LAT + DEF_WB_LAT : DEF_MISS_LAT;
  endfunction

  task automatic model_edge(input bit r, w, h, d, rs);
    m_edge++;
    e_done = 0;
    e_err  = 0;
    if (rs) begin
      m_pend = 0; m_hit = 0; m_miss = 0; m_drop = 0;
    end else if (m_pend) begin
      if (r | w) m_drop = (m_drop < SAT16) ? m_drop + 1 : m_drop;
      if (m_edge == m_done_edge) begin
        e_done = 1; e_op = m_op; e_wb = m_wb; m_pend = 0;
      end
    end else if (r | w) begin
      m_pend      = 1;
      m_done_edge = m_edge + lat_of(h, d);
      m_op        = r ? (h ? RD_HIT : RD_MISS) : (h ? WR_HIT : WR_MISS);
      m_wb        = ~h & d;
      e_err       = r & w;
      if (h) m_hit  = (m_hit  < SAT16) ? m_hit  + 1 : m_hit;
      else   m_miss = (m_miss < SAT16) ? m_miss + 1 : m_miss;
    end
    e_busy = m_pend;
  endtask

  vec_t tbl[24];

  initial begin
    // re we hit dirty rst | busy done op wb err | hit miss drop
    tbl[0]  = mk(0,0,0,0,1, 0,0,0,0,0, 0,0,0);
    tbl[1]  = mk(0,0,0,0,1, 0,0,0,0,0, 0,0,0);
    tbl[2]  = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0);
    tbl[3]  = mk(1,0,1,0,0, 1,0,0,0,0, 1,0,0);
    tbl[4]  = mk(0,0,0,0,0, 1,0,0,0,0, 1,0,0);
    tbl[5]  = mk(0,0,0,0,0, 0,1,0,0,0, 1,0,0);
    tbl[6]  = mk(0,1,0,1,0, 1,0,0,0,0, 1,1,0);
    tbl[7]  = mk(0,0,0,0,0, 1,0,0,0,0, 1,1,0);
    tbl[8]  = mk(0,0,0,0,0, 1,0,0,0,0, 1,1,0);
    tbl[9]  = mk(0,0,0,0,0, 1,0,0,0,0, 1,1,0);
    tbl[10] = mk(0,0,0,0,0, 1,0,0,0,0, 1,1,0);
    tbl[11] = mk(0,0,0,0,0, 0,1,3,1,0, 1,1,0);
    tbl[12] = mk(1,1,0,0,0, 1,0,0,0,1, 1,2,0);
    tbl[13] = mk(0,1,0,0,0, 1,0,0,0,0, 1,2,1);
    tbl[14] = mk(1,0,1,0,0, 1,0,0,0,0, 1,2,2);
    tbl[15] = mk(0,0,0,0,0, 0,1,1,0,0, 1,2,2);
    tbl[16] = mk(1,0,0,0,0, 1,0,0,0,0, 1,3,2);
    tbl[17] = mk(0,0,0,0,1, 0,0,0,0,0, 0,0,0);
    tbl[18] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0);
    tbl[19] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0);
    tbl[20] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0);
    tbl[21] = mk(0,1,1,0,0, 1,0,0,0,0, 1,0,0);
    tbl[22] = mk(0,0,0,0,0, 1,0,0,0,0, 1,0,0);
    tbl[23] = mk(0,0,0,0,0, 0,1,2,0,0, 1,0,0);

    for (int i = 0; i < 24; i++) begin
      re = tbl[i].re; we = tbl[i].we; hit = tbl[i].hit;
      dirty = tbl[i].dirty; rst = tbl[i].rst;
      @(posedge clk); #1;
      chk($sformatf("vec%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d done", i), done, tbl[i].done);
      chk($sformatf("vec%0d err", i), err, tbl[i].err);
      if (tbl[i].done) begin
        chk($sformatf("vec%0d done_op", i), done_op, tbl[i].op);
        chk($sformatf("vec%0d done_wb", i), done_wb, tbl[i].wb);
      end
      chk($sformatf("vec%0d hit_cnt", i), hit_cnt, STATS ? tbl[i].hc : 0);
      chk($sformatf("vec%0d miss_cnt", i), miss_cnt, STATS ? tbl[i].mc : 0);
      chk($sformatf("vec%0d drop_cnt", i), drop_cnt, STATS ? tbl[i].dc : 0);
    end

    // Random traffic against the model, starting from a reset edge.
    m_edge = 0; m_pend = 0; m_hit = 0; m_miss = 0; m_drop = 0;
    m_op = RD_HIT; e_op = RD_HIT; m_wb = 0; e_wb = 0; m_done_edge = 0;
    for (int c = 0; c < 1500; c++) begin
      rst   = (c == 0) || ($urandom_range(0, 99) == 0);
      re    = ($urandom_range(0, 2) == 0);
      we    = ($urandom_range(0, 2) == 0);
      hit   = $urandom_range(0, 1);
      dirty = $urandom_range(0, 1);
      @(posedge clk);
      model_edge(re, we, hit, dirty, rst);
      #1;
      chk("rnd busy", busy, e_busy);
      chk("rnd done", done, e_done);
      chk("rnd err", err, e_err);
      if (e_done) begin
        chk("rnd done_op", done_op, e_op);
        chk("rnd done_wb", done_wb, e_wb);
      end
      chk("rnd hit_cnt", hit_cnt, STATS ? m_hit : 0);
      chk("rnd miss_cnt", miss_cnt, STATS ? m_miss : 0);
      chk("rnd drop_cnt", drop_cnt, STATS ? m_drop : 0);
    end
    re = 0; we = 0; rst = 0;

    // HIT_LAT=1, hits held high: done every second edge, 2-bit counters saturate.
    f_rst = 1; @(posedge clk); #1;
    chk("fast reset busy", f_busy, 0);
    chk("fast reset hit_cnt", f_hit_cnt, 0);
    f_rst = 0; f_re = 1; f_hit = 1;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      chk($sformatf("fast%0d busy", j), f_busy, (j % 2) == 1);
      chk($sformatf("fast%0d done", j), f_done, (j % 2) == 0);
      if ((j % 2) == 0) chk($sformatf("fast%0d done_op", j), f_done_op, RD_HIT);
      chk($sformatf("fast%0d hit_cnt", j), f_hit_cnt,
          STATS ? (((j + 1) / 2 > 3) ? 3 : (j + 1) / 2) : 0);
      chk($sformatf("fast%0d drop_cnt", j), f_drop_cnt,
          STATS ? ((j / 2 > 3) ? 3 : j / 2) : 0);
    end
    f_re = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
